// File: rtl/regfile_pkg.sv
// Shared register-file constants and requester indices for the writeback arbiter.
// Also holds the small pointer-wrap helper used by the round-robin build.
package regfile_pkg;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 8;
   localparam int SP_INDEX = 2;
   localparam logic [15:0] SP_RESET = 16'd256;

   localparam int REQ_ALU  = 0;
   localparam int REQ_LOAD = 1;
   localparam int REQ_SP   = 2;

   function automatic int wrap_inc(input int i, input int n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_picker.sv
// Combinational grant picker: first full buffer found searching upward from ptr (wrapping).
// A pointer tied to zero gives plain lowest-index-wins priority.
module regarb_picker #(
   parameter int NUM_REQ = 3,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] full,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               grant_valid
);

   always_comb begin
      int idx;
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      idx         = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!grant_valid && full[idx]) begin
            grant[idx]  = 1'b1;
            grant_idx   = idx[ID_W-1:0];
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between NUM_REQ one-entry writeback buffers.
// Define REGARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module regfile_write_arbiter
   import regfile_pkg::wrap_inc;
#(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = regfile_pkg::DATA_W,
   parameter int ADDR_W  = regfile_pkg::ADDR_W,
   parameter int ID_W    = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
   input  logic [DATA_W*NUM_REQ-1:0] req_data,
   output logic [ADDR_W-1:0]         writeReg,
   output logic [DATA_W-1:0]         writeFile,
   output logic                      regWrite,
   output logic [ID_W-1:0]           grant_id,
   output logic                      busy
);

   logic [NUM_REQ-1:0]             full_q, full_d;
   logic [NUM_REQ-1:0][ADDR_W-1:0] buf_addr_q, buf_addr_d;
   logic [NUM_REQ-1:0][DATA_W-1:0] buf_data_q, buf_data_d;
   logic [ADDR_W-1:0]              write_reg_q, write_reg_d;
   logic [DATA_W-1:0]              write_file_q, write_file_d;
   logic                           reg_write_q, reg_write_d;
   logic [ID_W-1:0]                grant_id_q, grant_id_d;

   logic [NUM_REQ-1:0] grant_oh;
   logic [ID_W-1:0]    grant_idx;
   logic               grant_valid;
   logic [ID_W-1:0]    pick_ptr;

`ifdef REGARB_ROUND_ROBIN_EN
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

   // Pointer moves just past the winner; idle cycles leave it alone.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_valid) rr_ptr_d = ID_W'(wrap_inc(int'(grant_idx), NUM_REQ));
   end

   always_ff @(posedge clock) begin
      if (reset) rr_ptr_q <= '0;
      else       rr_ptr_q <= rr_ptr_d;
   end

   assign pick_ptr = rr_ptr_q;
`else
   assign pick_ptr = '0;
`endif

   regarb_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .full        (full_q),
      .ptr         (pick_ptr),
      .grant       (grant_oh),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // A granted buffer drains this cycle, so it can take a new write at the same edge.
   assign req_ready = ~full_q | grant_oh;
   assign busy      = (|full_q) | reg_write_q;

   always_comb begin
      full_d       = full_q;
      buf_addr_d   = buf_addr_q;
      buf_data_d   = buf_data_q;
      write_reg_d  = write_reg_q;
      write_file_d = write_file_q;
      reg_write_d  = 1'b0;
      grant_id_d   = grant_id_q;
      if (grant_valid) begin
         write_reg_d  = buf_addr_q[grant_idx];
         write_file_d = buf_data_q[grant_idx];
         reg_write_d  = 1'b1;
         grant_id_d   = grant_idx;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_oh[i]) full_d[i] = 1'b0;
         if (req_valid[i] && req_ready[i]) begin
            full_d[i]     = 1'b1;
            buf_addr_d[i] = req_addr[ADDR_W*i +: ADDR_W];
            buf_data_d[i] = req_data[DATA_W*i +: DATA_W];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         full_q       <= '0;
         buf_addr_q   <= '0;
         buf_data_q   <= '0;
         write_reg_q  <= '0;
         write_file_q <= '0;
         reg_write_q  <= 1'b0;
         grant_id_q   <= '0;
      end else begin
         full_q       <= full_d;
         buf_addr_q   <= buf_addr_d;
         buf_data_q   <= buf_data_d;
         write_reg_q  <= write_reg_d;
         write_file_q <= write_file_d;
         reg_write_q  <= reg_write_d;
         grant_id_q   <= grant_id_d;
      end
   end

   assign writeReg  = write_reg_q;
   assign writeFile = write_file_q;
   assign regWrite  = reg_write_q;
   assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a cycle model and an expected-write queue.
// Honours REGARB_ROUND_ROBIN_EN the same way as the design.
module tb_regfile_write_arbiter;
   import regfile_pkg::*;

   localparam int N  = 3;
   localparam int AW = 3;
   localparam int DW = 16;
   localparam int IW = 2;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [AW-1:0]   writeReg;
   logic [DW-1:0]   writeFile;
   logic            regWrite;
   logic [IW-1:0]   grant_id;
   logic            busy;

   regfile_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .ID_W(IW)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .writeReg  (writeReg),
      .writeFile (writeFile),
      .regWrite  (regWrite),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [IW-1:0] id;
   } wr_t;

   logic [N-1:0]  m_full = '0;
   logic [AW-1:0] m_addr [N];
   logic [DW-1:0] m_data [N];
   int            m_ptr = 0;
   logic          m_rw = 1'b0;
   logic [N-1:0]  m_acc = '0;
   wr_t           expq [$];
   bit            chk_en = 1'b0;
   int            checks = 0;
   int            passes = 0;
   int            cnt = 0;

   function automatic int model_pick();
      int idx;
      for (int k = 0; k < N; k++) begin
`ifdef REGARB_ROUND_ROBIN_EN
         idx = (m_ptr + k) % N;
`else
         idx = k;
`endif
         if (m_full[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[AW*i +: AW] = a;
      req_data[DW*i +: DW] = d;
   endtask

   // One clock: check ready, advance the model at the edge, then check outputs.
   task automatic apply_stimulus(input logic rst);
      int           g;
      logic [N-1:0] rdy;
      wr_t          w;
      wr_t          e;
      g   = model_pick();
      rdy = ~m_full;
      if (g >= 0) rdy[g] = 1'b1;
      reset = rst;
      if (chk_en) check_output("req_ready", 32'(req_ready), 32'(rdy));
      @(posedge clock);
      m_acc = '0;
      if (rst) begin
         m_full = '0;
         m_ptr  = 0;
         m_rw   = 1'b0;
         expq.delete();
         chk_en = 1'b1;
      end else begin
         m_rw = (g >= 0);
         if (g >= 0) begin
            w.a  = m_addr[g];
            w.d  = m_data[g];
            w.id = g[IW-1:0];
            expq.push_back(w);
            m_full[g] = 1'b0;
            m_ptr = (g + 1) % N;
         end
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && rdy[i]) begin
               m_acc[i]  = 1'b1;
               m_full[i] = 1'b1;
               m_addr[i] = req_addr[AW*i +: AW];
               m_data[i] = req_data[DW*i +: DW];
            end
         end
      end
      #1;
      if (chk_en) begin
         check_output("regWrite", 32'(regWrite), 32'(m_rw));
         check_output("busy", 32'(busy), 32'((|m_full) | m_rw));
         if (m_rw && expq.size() > 0) begin
            e = expq.pop_front();
            check_output("writeReg", 32'(writeReg), 32'(e.a));
            check_output("writeFile", 32'(writeFile), 32'(e.d));
            check_output("grant_id", 32'(grant_id), 32'(e.id));
         end
      end
   endtask

   // Give every accepted requester fresh, distinct data for the next cycle.
   task automatic refresh_accepted();
      for (int i = 0; i < N; i++) begin
         if (m_acc[i]) begin
            cnt++;
            set_req(i, AW'(cnt + i), DW'((i << 12) | cnt));
         end
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         m_addr[i] = '0;
         m_data[i] = '0;
      end

      $display("[TB] reset with all requesters valid");
      req_valid = 3'b111;
      set_req(0, 3'd1, 16'hAAAA);
      set_req(1, 3'd3, 16'hBBBB);
      set_req(2, 3'd6, 16'hCCCC);
      apply_stimulus(1'b1);
      apply_stimulus(1'b1);
      req_valid = '0;
      apply_stimulus(1'b0);
      check_output("rst_regWrite", 32'(regWrite), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_ready", 32'(req_ready), 32'h7);

      $display("[TB] single write");
      req_valid = 3'b001;
      set_req(REQ_ALU, 3'd5, 16'h1234);
      apply_stimulus(1'b0);
      req_valid = '0;
      apply_stimulus(1'b0);
      check_output("single_pulse", 32'(regWrite), 32'd1);
      check_output("single_addr", 32'(writeReg), 32'd5);
      check_output("single_data", 32'(writeFile), 32'h1234);
      check_output("single_id", 32'(grant_id), 32'd0);
      apply_stimulus(1'b0);
      check_output("single_done", 32'(regWrite), 32'd0);

      $display("[TB] contention");
      apply_stimulus(1'b1);
      req_valid = 3'b111;
      set_req(0, 3'd1, 16'h0001);
      set_req(1, 3'd2, 16'h1001);
      set_req(2, 3'd3, 16'h2001);
      for (int s = 1; s <= 8; s++) begin
         apply_stimulus(1'b0);
         refresh_accepted();
         if (s >= 2) begin
            check_output("cont_pulse", 32'(regWrite), 32'd1);
`ifdef REGARB_ROUND_ROBIN_EN
            check_output("cont_rr_id", 32'(grant_id), 32'((s - 2) % 3));
`else
            check_output("cont_fp_id", 32'(grant_id), 32'd0);
`endif
         end
`ifndef REGARB_ROUND_ROBIN_EN
         check_output("cont_fp_ready", 32'(req_ready[2:1]), 32'd0);
`endif
      end
      req_valid = 3'b110;
      apply_stimulus(1'b0);
      refresh_accepted();
      req_valid = '0;
      apply_stimulus(1'b0);
`ifndef REGARB_ROUND_ROBIN_EN
      check_output("fp_after_drop_id", 32'(grant_id), 32'd1);
`endif
      for (int s = 0; s < 5; s++) apply_stimulus(1'b0);
      check_output("cont_drained", 32'(expq.size()), 32'd0);
      check_output("cont_idle_busy", 32'(busy), 32'd0);

      $display("[TB] same-register collision");
      apply_stimulus(1'b1);
      req_valid = 3'b011;
      set_req(REQ_ALU, 3'(SP_INDEX), 16'h0100);
      set_req(REQ_LOAD, 3'(SP_INDEX), 16'h00FE);
      apply_stimulus(1'b0);
      req_valid = '0;
      apply_stimulus(1'b0);
      check_output("coll_first", 32'(writeFile), 32'h0100);
      apply_stimulus(1'b0);
      check_output("coll_last_data", 32'(writeFile), 32'h00FE);
      check_output("coll_last_addr", 32'(writeReg), 32'd2);
      check_output("coll_last_id", 32'(grant_id), 32'd1);
      apply_stimulus(1'b0);

      $display("[TB] reset mid-operation");
      req_valid = 3'b101;
      set_req(REQ_ALU, 3'd4, 16'h4444);
      set_req(REQ_SP, 3'd2, SP_RESET);
      apply_stimulus(1'b0);
      req_valid = '0;
      apply_stimulus(1'b1);
      check_output("mid_rst_rw", 32'(regWrite), 32'd0);
      check_output("mid_rst_busy", 32'(busy), 32'd0);
      check_output("mid_rst_ready", 32'(req_ready), 32'h7);
      apply_stimulus(1'b0);
      check_output("mid_rst_nowrite", 32'(regWrite), 32'd0);
      req_valid = 3'b010;
      set_req(REQ_LOAD, 3'd7, 16'hBEEF);
      apply_stimulus(1'b0);
      req_valid = '0;
      apply_stimulus(1'b0);
      check_output("post_rst_rw", 32'(regWrite), 32'd1);
      check_output("post_rst_addr", 32'(writeReg), 32'd7);
      check_output("post_rst_data", 32'(writeFile), 32'hBEEF);
      check_output("post_rst_id", 32'(grant_id), 32'd1);
      apply_stimulus(1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
